// File: rtl/inmultire_secv_if.sv
// Request/response bundle for the sequential signed multiplier.
interface inmultire_secv_if #(
    parameter int unsigned W = 28
);
    logic         valid_in;
    logic [W-1:0] n1;
    logic [W-1:0] n2;
    logic         busy;
    logic         valid_out;
    logic         ovf;
    logic [W-1:0] p_out;

    // Requester side: drives operands and strobe, observes status and result
    modport master (
        output valid_in,
        output n1,
        output n2,
        input  busy,
        input  valid_out,
        input  ovf,
        input  p_out
    );

    // Multiplier side: samples operands, returns status and result
    modport slave (
        input  valid_in,
        input  n1,
        input  n2,
        output busy,
        output valid_out,
        output ovf,
        output p_out
    );
endinterface

// File: rtl/inmultire_secv.sv
// Sequential signed multiplier: sign-magnitude shift-add, one multiplier bit
// per cycle, saturated W-bit signed result with overflow flag.
module inmultire_secv #(
    parameter int unsigned W = 28
) (
    input  logic             clk,
    input  logic             reset,
    inmultire_secv_if.slave  bus
);
    localparam int unsigned AW = 2 * W;
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    // Magnitude limits for a negative / non-negative W-bit result
    localparam logic [AW-1:0] LIM_NEG  = AW'(1) << (W - 1);
    localparam logic [AW-1:0] LIM_POS  = LIM_NEG - AW'(1);
    localparam logic [W-1:0]  SAT_NEG  = {1'b1, {(W - 1){1'b0}}};
    localparam logic [W-1:0]  SAT_POS  = {1'b0, {(W - 1){1'b1}}};
    localparam logic [CW-1:0] CNT_LOAD = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [CW-1:0]  r_cnt;
    logic [AW-1:0]  r_mcand;
    logic [W-1:0]   r_mplier;
    logic [AW-1:0]  r_acc;
    logic           r_sign_a;
    logic           r_sign_b;
    logic           r_busy;
    logic           r_valid_out;
    logic           r_ovf;
    logic [W-1:0]   r_p_out;

    logic [CW-1:0]  w_cnt_nxt;
    logic [AW-1:0]  w_mcand_nxt;
    logic [W-1:0]   w_mplier_nxt;
    logic [AW-1:0]  w_acc_nxt;
    logic           w_sign_a_nxt;
    logic           w_sign_b_nxt;
    logic           w_busy_nxt;
    logic           w_valid_out_nxt;
    logic           w_ovf_nxt;
    logic [W-1:0]   w_p_out_nxt;

    logic [W-1:0]   w_mag_n1;
    logic [W-1:0]   w_mag_n2;
    logic           w_neg;
    logic [AW-1:0]  w_limit;
    logic [W-1:0]   w_p_signed;

    // Operand magnitudes; the most negative value maps to 2^(W-1) unsigned
    always_comb begin
        w_mag_n1 = bus.n1[W-1] ? W'(-bus.n1) : bus.n1;
        w_mag_n2 = bus.n2[W-1] ? W'(-bus.n2) : bus.n2;
    end

    // Result sign, saturation limit and in-range signed result
    always_comb begin
        w_neg      = (r_sign_a ^ r_sign_b) && (r_acc != '0);
        w_limit    = w_neg ? LIM_NEG : LIM_POS;
        w_p_signed = w_neg ? W'(-r_acc[W-1:0]) : r_acc[W-1:0];
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (bus.valid_in) w_state_nxt = S_RUN;
            S_RUN:  if (r_cnt == '0)  w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and output next values per state
    always_comb begin
        w_cnt_nxt       = r_cnt;
        w_mcand_nxt     = r_mcand;
        w_mplier_nxt    = r_mplier;
        w_acc_nxt       = r_acc;
        w_sign_a_nxt    = r_sign_a;
        w_sign_b_nxt    = r_sign_b;
        w_valid_out_nxt = 1'b0;
        w_ovf_nxt       = r_ovf;
        w_p_out_nxt     = r_p_out;
        w_busy_nxt      = (w_state_nxt != S_IDLE);

        case (r_state)
            S_IDLE: begin
                if (bus.valid_in) begin
                    w_sign_a_nxt = bus.n1[W-1];
                    w_sign_b_nxt = bus.n2[W-1];
                    w_mcand_nxt  = {{W{1'b0}}, w_mag_n1};
                    w_mplier_nxt = w_mag_n2;
                    w_acc_nxt    = '0;
                    w_cnt_nxt    = CNT_LOAD;
                end
            end
            S_RUN: begin
                // Multiplicand is kept pre-shifted, so bit i of the multiplier
                // always meets mag_a << i.
                if (r_mplier[0]) begin
                    w_acc_nxt = r_acc + r_mcand;
                end
                w_mcand_nxt  = r_mcand << 1;
                w_mplier_nxt = r_mplier >> 1;
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_DONE: begin
                w_valid_out_nxt = 1'b1;
                if (r_acc > w_limit) begin
                    w_ovf_nxt   = 1'b1;
                    w_p_out_nxt = w_neg ? SAT_NEG : SAT_POS;
                end else begin
                    w_ovf_nxt   = 1'b0;
                    w_p_out_nxt = w_p_signed;
                end
            end
            default: begin
                w_valid_out_nxt = 1'b0;
            end
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_sign_a    <= 1'b0;
            r_sign_b    <= 1'b0;
            r_busy      <= 1'b0;
            r_valid_out <= 1'b0;
            r_ovf       <= 1'b0;
            r_p_out     <= '0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_mcand     <= w_mcand_nxt;
            r_mplier    <= w_mplier_nxt;
            r_acc       <= w_acc_nxt;
            r_sign_a    <= w_sign_a_nxt;
            r_sign_b    <= w_sign_b_nxt;
            r_busy      <= w_busy_nxt;
            r_valid_out <= w_valid_out_nxt;
            r_ovf       <= w_ovf_nxt;
            r_p_out     <= w_p_out_nxt;
        end
    end

    assign bus.busy      = r_busy;
    assign bus.valid_out = r_valid_out;
    assign bus.ovf       = r_ovf;
    assign bus.p_out     = r_p_out;

endmodule

// File: tb/tb_inmultire_secv.sv
// Directed bench for the sequential signed multiplier.
module tb_inmultire_secv;
    localparam int unsigned W = 28;
    localparam int TIMEOUT = 40;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    inmultire_secv_if #(.W(W)) bus();

    inmultire_secv #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] p;
        logic         o;
        string        name;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one request and wait for its result; checks latency, busy span and pulse width
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] p, output logic o, output int lat);
        int nbusy;
        @(negedge clk);
        bus.valid_in = 1'b1;
        bus.n1 = a;
        bus.n2 = b;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        bus.n1 = W'($urandom);
        bus.n2 = W'($urandom);
        lat = 0;
        nbusy = 0;
        while (!bus.valid_out && lat < TIMEOUT) begin
            if (bus.busy) nbusy++;
            @(posedge clk);
            #1;
            lat++;
        end
        p = bus.p_out;
        o = bus.ovf;
        if (lat >= TIMEOUT) begin
            check("op_timeout", 64'(lat), 64'(W + 1));
        end else begin
            check("busy_cycles", 64'(nbusy), 64'(W + 1));
            check("busy_in_valid_cycle", 64'(bus.busy), 64'd0);
            @(posedge clk);
            #1;
            check("valid_pulse_width", 64'(bus.valid_out), 64'd0);
        end
    endtask

    initial begin
        logic [W-1:0] p;
        logic         o;
        int           lat;
        int           seen;

        vecs[0]  = '{28'd6,        28'd7,        28'd42,        1'b0, "6x7"};
        vecs[1]  = '{28'hFFFFFFB,  28'd9,        28'hFFFFFD3,   1'b0, "-5x9"};
        vecs[2]  = '{28'd0,        28'hFFFFFFD,  28'd0,         1'b0, "0x-3"};
        vecs[3]  = '{28'h8000000,  28'd1,        28'h8000000,   1'b0, "minx1"};
        vecs[4]  = '{28'h8000000,  28'hFFFFFFF,  28'h7FFFFFF,   1'b1, "minx-1"};
        vecs[5]  = '{28'd20000,    28'd20000,    28'h7FFFFFF,   1'b1, "big_pos"};
        vecs[6]  = '{28'd20000,    28'hFFFB1E0,  28'h8000000,   1'b1, "big_neg"};
        vecs[7]  = '{28'hFFFFFF9,  28'hFFFFFF8,  28'd56,        1'b0, "-7x-8"};
        vecs[8]  = '{28'h7FFFFFF,  28'd1,        28'h7FFFFFF,   1'b0, "maxx1"};
        vecs[9]  = '{28'hFFFFFFF,  28'hFFFFFFF,  28'd1,         1'b0, "-1x-1"};
        vecs[10] = '{28'h8000000,  28'h8000000,  28'h7FFFFFF,   1'b1, "minxmin"};
        vecs[11] = '{28'd8192,     28'd16384,    28'h7FFFFFF,   1'b1, "2^27_pos"};
        vecs[12] = '{28'hFFFE000,  28'd16384,    28'h8000000,   1'b0, "-2^27_fits"};

        reset = 1'b1;
        bus.valid_in = 1'b0;
        bus.n1 = '0;
        bus.n2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  64'(bus.busy),      64'd0);
        check("rst_valid", 64'(bus.valid_out), 64'd0);
        check("rst_ovf",   64'(bus.ovf),       64'd0);
        check("rst_p",     64'(bus.p_out),     64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven products
        for (int i = 0; i < 13; i++) begin
            do_op(vecs[i].a, vecs[i].b, p, o, lat);
            check({vecs[i].name, "_p"},   64'(p),   64'(vecs[i].p));
            check({vecs[i].name, "_ovf"}, 64'(o),   64'(vecs[i].o));
            check({vecs[i].name, "_lat"}, 64'(lat), 64'(W + 1));
        end

        // valid_in held with operands changing each cycle: accepts at 0, 30, 60
        for (int e = 0; e < 90; e++) begin
            @(negedge clk);
            bus.valid_in = 1'b1;
            bus.n1 = W'(e + 1);
            bus.n2 = W'(e + 2);
            @(posedge clk);
            #1;
            if (e == 29 || e == 59 || e == 89) begin
                check("hold_valid", 64'(bus.valid_out), 64'd1);
                check("hold_busy",  64'(bus.busy),      64'd0);
                check("hold_p", 64'(bus.p_out),
                      (e == 29) ? 64'd2 : (e == 59) ? 64'd992 : 64'd3782);
                check("hold_ovf", 64'(bus.ovf), 64'd0);
            end else begin
                check("hold_novalid", 64'(bus.valid_out), 64'd0);
                check("hold_busy",    64'(bus.busy),      64'd1);
            end
        end
        @(negedge clk);
        bus.valid_in = 1'b0;
        @(posedge clk);
        #1;
        check("hold_end_busy",  64'(bus.busy),      64'd0);
        check("hold_end_valid", 64'(bus.valid_out), 64'd0);

        // Reset during the 10th RUN cycle of 3x3
        @(negedge clk);
        bus.valid_in = 1'b1;
        bus.n1 = 28'd3;
        bus.n2 = 28'd3;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_busy",  64'(bus.busy),      64'd0);
        check("abort_p",     64'(bus.p_out),     64'd0);
        check("abort_valid", 64'(bus.valid_out), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (TIMEOUT) begin
            @(posedge clk);
            #1;
            if (bus.valid_out) seen++;
        end
        check("abort_no_pulse", 64'(seen), 64'd0);
        do_op(28'd3, 28'd3, p, o, lat);
        check("after_abort_p",   64'(p),   64'd9);
        check("after_abort_ovf", 64'(o),   64'd0);
        check("after_abort_lat", 64'(lat), 64'(W + 1));

        // Reset coincident with valid_in drops the request
        @(negedge clk);
        reset = 1'b1;
        bus.valid_in = 1'b1;
        bus.n1 = 28'd5;
        bus.n2 = 28'd5;
        @(negedge clk);
        reset = 1'b0;
        bus.valid_in = 1'b0;
        @(posedge clk);
        #1;
        check("rst_req_busy", 64'(bus.busy), 64'd0);
        seen = 0;
        repeat (TIMEOUT) begin
            @(posedge clk);
            #1;
            if (bus.valid_out) seen++;
        end
        check("rst_req_no_pulse", 64'(seen), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
